// File: rtl/mul_rr_sched.sv
// mul_rr_sched: round-robin scheduler that shares one pipelined W x W
// multiplier among N requesters and routes each product back to the
// requester that supplied the operands.
//
// Ports:
//   clk, rst             single clock; synchronous active-high reset
//   req_valid[N]         requester i presents an operand pair
//   req_a/req_b[N*W]     requester i operands in bits [i*W +: W]
//   req_ready[N]         combinational one-hot grant (zero when halted/reset)
//   halt                 blocks new grants; in-flight work still completes
//   mul_a/mul_b[W]       registered operands to the external multiplier
//   mul_s[2W]            multiplier product, valid MUL_LAT cycles after operands
//   rsp_valid[N]         one-hot marker of the requester owning rsp_s
//   rsp_s[2W]            registered result
//   busy                 an accepted request has not yet responded
module mul_rr_sched #(
    parameter int W       = 32,
    parameter int N       = 4,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    input  logic             halt,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_s,
    output logic [N-1:0]     rsp_valid,
    output logic [2*W-1:0]   rsp_s,
    output logic             busy
);

    localparam int IDW = $clog2(N);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;

    logic [W-1:0]   mul_a_q, mul_a_d;
    logic [W-1:0]   mul_b_q, mul_b_d;

    // Tag pipeline: stage k holds the transfer accepted k+1 cycles ago, so
    // stage MUL_LAT lines up with the cycle mul_s carries its product.
    logic [MUL_LAT:0] tag_v_q, tag_v_d;
    logic [IDW-1:0]   tag_id_q [MUL_LAT+1];
    logic [IDW-1:0]   tag_id_d [MUL_LAT+1];

    logic [N-1:0]     rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]   rsp_s_q, rsp_s_d;
    logic             busy_q, busy_d;

    // Round-robin search starting at ptr, wrapping modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        if (!rst && !halt) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = IDW'((32'(ptr_q) + k) % N);
                if (!gnt_found && req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (gnt_found) begin
            ptr_d   = IDW'((32'(gnt_idx) + 1) % N);
            mul_a_d = req_a[gnt_idx*W +: W];
            mul_b_d = req_b[gnt_idx*W +: W];
        end

        tag_v_d     = '0;
        tag_v_d[0]  = gnt_found;
        tag_id_d[0] = gnt_idx;
        for (int unsigned k = 1; k <= MUL_LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end

        rsp_valid_d = '0;
        rsp_s_d     = rsp_s_q;
        if (tag_v_q[MUL_LAT]) begin
            rsp_valid_d[tag_id_q[MUL_LAT]] = 1'b1;
            rsp_s_d                        = mul_s;
        end

        // Covers the span from the cycle after acceptance through the
        // response cycle itself.
        busy_d = (|tag_v_d) | (|rsp_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_v_q     <= '0;
            rsp_valid_q <= '0;
            rsp_s_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_v_q     <= tag_v_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            busy_q      <= busy_d;
        end
        for (int unsigned k = 0; k <= MUL_LAT; k++) begin
            tag_id_q[k] <= tag_id_d[k];
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched (N=4, W=32, MUL_LAT=4): directed cycle table,
// a hand-written full-width product sequence, then random traffic against
// a queue-based reference model.
module tb_mul_rr_sched;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             halt;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     mul_a, mul_b;
    logic [2*W-1:0]   mul_s;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_s;
    logic             busy;

    logic [W-1:0]     opa [N];
    logic [W-1:0]     opb [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    end

    // External multiplier with LAT register stages.
    logic [2*W-1:0] pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        pipe[0] <= 64'(mul_a) * 64'(mul_b);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_s = pipe[LAT-1];

    mul_rr_sched #(.W(W), .N(N), .MUL_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .halt      (halt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_s     (mul_s),
        .rsp_valid (rsp_valid),
        .rsp_s     (rsp_s),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 4)
            0: rnd_op = '1;
            1: rnd_op = '0;
            default: rnd_op = W'($urandom);
        endcase
    endfunction

    typedef struct {
        int         rep;
        logic       rst;
        logic       halt;
        logic [3:0] valid;
        logic [3:0] rdy;
        logic [3:0] rsp;
        logic       busy;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [63:0] p;
    } resp_t;

    vec_t  vt [34];
    resp_t q [$];

    initial begin
        int          id;
        int          g;
        int          m_ptr;
        int          cyc;
        logic [3:0]  pend;
        logic [3:0]  want_rdy, want_rsp;
        logic [63:0] want_rs, m_rs;
        logic [W-1:0] m_ma, m_mb;

        // rep, rst, halt, valid, ready, rsp_valid, busy
        vt[0]  = '{1, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
        vt[1]  = '{1, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0};
        vt[2]  = '{1, 1'b0, 1'b0, 4'b1111, 4'b0010, 4'b0000, 1'b1};
        vt[3]  = '{1, 1'b0, 1'b0, 4'b1111, 4'b0100, 4'b0000, 1'b1};
        vt[4]  = '{1, 1'b0, 1'b0, 4'b1111, 4'b1000, 4'b0000, 1'b1};
        vt[5]  = '{2, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1};
        vt[6]  = '{1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b1};
        vt[7]  = '{1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b1};
        vt[8]  = '{1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0100, 1'b1};
        vt[9]  = '{1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1};
        vt[10] = '{1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
        vt[11] = '{1, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0};
        vt[12] = '{1, 1'b0, 1'b0, 4'b1001, 4'b1000, 4'b0000, 1'b1};
        vt[13] = '{1, 1'b0, 1'b0, 4'b1001, 4'b0001, 4'b0000, 1'b1};
        vt[14] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vt[15] = '{2, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1};
        vt[16] = '{1, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0010, 1'b1};
        vt[17] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b1};
        vt[18] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        vt[19] = '{3, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vt[20] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b1};
        vt[21] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[22] = '{1, 1'b0, 1'b0, 4'b0111, 4'b0001, 4'b0000, 1'b0};
        vt[23] = '{1, 1'b0, 1'b0, 4'b0110, 4'b0010, 4'b0000, 1'b1};
        vt[24] = '{1, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1};
        vt[25] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vt[26] = '{1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vt[27] = '{6, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vt[28] = '{1, 1'b0, 1'b0, 4'b1010, 4'b0010, 4'b0000, 1'b0};
        vt[29] = '{1, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1};
        vt[30] = '{4, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vt[31] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1};
        vt[32] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b1};
        vt[33] = '{1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        for (int i = 0; i < N; i++) begin
            opa[i] = 32'hA000_0000 + 32'(i);
            opb[i] = 32'h0000_1000 * 32'(i + 3);
        end
        rst = 1'b1; halt = 1'b0; req_valid = '0;
        next_cycle();
        next_cycle();

        // Directed table
        for (int r = 0; r < 34; r++) begin
            for (int k = 0; k < vt[r].rep; k++) begin
                rst = vt[r].rst; halt = vt[r].halt; req_valid = vt[r].valid;
                @(negedge clk);
                chk("tbl_ready", 64'(req_ready), 64'(vt[r].rdy));
                chk("tbl_rsp_valid", 64'(rsp_valid), 64'(vt[r].rsp));
                chk("tbl_busy", 64'(busy), 64'(vt[r].busy));
                if (vt[r].rsp != 4'b0000) begin
                    id = 0;
                    for (int i = 0; i < N; i++) if (vt[r].rsp[i]) id = i;
                    chk("tbl_rsp_s", rsp_s, 64'(opa[id]) * 64'(opb[id]));
                end
                next_cycle();
            end
        end

        // Full-width product through requester 0
        rst = 1'b1; halt = 1'b0; req_valid = '0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        opa[0] = 32'hFFFF_FFFF; opb[0] = 32'hFFFF_FFFF;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("max_ready", 64'(req_ready), 64'(4'b0001));
        next_cycle();
        req_valid = '0;
        for (int d = 1; d <= 7; d++) begin
            @(negedge clk);
            if (d == 1) begin
                chk("max_mul_a", 64'(mul_a), 64'hFFFF_FFFF);
                chk("max_mul_b", 64'(mul_b), 64'hFFFF_FFFF);
            end
            chk("max_rsp_valid", 64'(rsp_valid), (d == 6) ? 64'd1 : 64'd0);
            if (d == 6) chk("max_rsp_s", rsp_s, 64'hFFFF_FFFE_0000_0001);
            next_cycle();
        end

        // Random traffic against the reference model
        rst = 1'b1; halt = 1'b0; req_valid = '0; pend = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        m_ptr = 0; m_rs = '0; m_ma = '0; m_mb = '0; cyc = 0;
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    opa[i]  = rnd_op();
                    opb[i]  = rnd_op();
                end
            end
            req_valid = pend;
            halt = ($urandom % 6 == 0);
            rst  = ($urandom % 80 == 0);
            @(negedge clk);

            g = -1;
            if (!rst && !halt) begin
                for (int k = 0; k < N; k++) begin
                    id = (m_ptr + k) % N;
                    if (g < 0 && pend[id]) g = id;
                end
            end
            want_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            want_rsp = 4'b0000;
            want_rs  = m_rs;
            if (q.size() > 0 && q[0].due == cyc) begin
                want_rsp = 4'(1 << q[0].id);
                want_rs  = q[0].p;
            end
            chk("rnd_ready", 64'(req_ready), 64'(want_rdy));
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(want_rsp));
            chk("rnd_rsp_s", rsp_s, want_rs);
            chk("rnd_busy", 64'(busy), 64'(q.size() != 0));
            chk("rnd_mul_a", 64'(mul_a), 64'(m_ma));
            chk("rnd_mul_b", 64'(mul_b), 64'(m_mb));

            if (rst) begin
                q.delete();
                m_ptr = 0; m_rs = '0; m_ma = '0; m_mb = '0;
            end else begin
                if (want_rsp != 4'b0000) begin
                    m_rs = want_rs;
                    void'(q.pop_front());
                end
                if (g >= 0) begin
                    q.push_back('{cyc + LAT + 2, g, 64'(opa[g]) * 64'(opb[g])});
                    m_ma    = opa[g];
                    m_mb    = opb[g];
                    m_ptr   = (g + 1) % N;
                    pend[g] = 1'b0;
                end
            end
            next_cycle();
            cyc++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_rr_sched.md
MUL_RR_SCHED -- requirements
Module: mul_rr_sched

Interface
REQ-001 SHALL have parameter W, default 32: operand width of the shared multiplier.
REQ-002 SHALL have parameter N, default 4: number of requesters, with 2 <= N <= 8.
REQ-003 SHALL have parameter MUL_LAT, default 4: operands driven on mul_a/mul_b in cycle c produce their product on mul_s in cycle c+MUL_LAT; MUL_LAT >= 1.
REQ-004 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req_valid  in  N  bit i high: requester i presents an operand pair.
REQ-007 req_a  in  N*W  requester i operand A is in bits [i*W +: W].
REQ-008 req_b  in  N*W  requester i operand B is in bits [i*W +: W].
REQ-009 req_ready  out  N  grant; one-hot or zero.
REQ-010 halt  in  1  while high, no new grants are issued.
REQ-011 mul_a  out  W  operand A to the multiplier; registered.
REQ-012 mul_b  out  W  operand B to the multiplier; registered.
REQ-013 mul_s  in  2W  product from the multiplier.
REQ-014 rsp_valid  out  N  one-hot or zero; bit i marks rsp_s as the result for requester i.
REQ-015 rsp_s  out  2W  result; registered.
REQ-016 busy  out  1  high while any accepted request has no response yet.

Function
REQ-017 A transfer for requester i SHALL occur in any cycle where req_valid[i] and req_ready[i] are both high; requesters hold valid/a/b stable until that cycle.
REQ-018 req_ready SHALL be combinational from req_valid, halt and the pointer; at most one bit is high; no bit is high when halt=1 or req_valid=0.
REQ-019 Arbitration SHALL be round-robin: the granted index is the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N.
REQ-020 After a grant to index g, ptr SHALL become (g+1) mod N; with no grant, ptr SHALL hold.
REQ-021 A transfer in cycle t SHALL drive mul_a/mul_b with that pair in cycle t+1; with no transfer, mul_a/mul_b SHALL hold their previous values.
REQ-022 A tag shift pipeline of depth MUL_LAT+1 (valid bit plus log2(N)-bit id) SHALL track each transfer, aligned so that the entry reaches the output in the cycle mul_s carries its product.
REQ-023 For a transfer in cycle t, rsp_valid[id] SHALL be high for exactly one cycle, t+MUL_LAT+2, with rsp_s equal to the registered mul_s; total latency is MUL_LAT+2.
REQ-024 In cycles with no tag arriving, rsp_valid SHALL be 0 and rsp_s SHALL hold its last value.
REQ-025 Throughput SHALL be one transfer per cycle sustained; responses are never back-pressured; results leave in acceptance order.
REQ-026 halt SHALL block only new grants; in-flight operations SHALL complete and respond normally; a halt that rises in the same cycle as a req_valid rise SHALL block that grant.
REQ-027 busy SHALL be high from the cycle after a transfer until the cycle its rsp_valid is high, inclusive; otherwise low.
REQ-028 Product arithmetic SHALL be unsigned W x W -> 2W; the block SHALL NOT modify mul_s.

Reset
REQ-029 When rst=1 at a rising edge: ptr=0; all tag valids=0; mul_a=0; mul_b=0; rsp_s=0; rsp_valid=0; busy=0.
REQ-030 While rst=1, req_ready SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; none of them SHALL ever produce rsp_valid, even though mul_s may still show their products.

Verification
REQ-032 Setup N=4, MUL_LAT=4. Single request: req_valid=0001, a=0xFFFFFFFF, b=0xFFFFFFFF accepted in cycle 10 -> mul_a=0xFFFFFFFF in cycle 11; rsp_valid=0001 with rsp_s=0xFFFFFFFE00000001 in cycle 16 only.
REQ-033 Round-robin: all four valid continuously from reset -> grants in order 0,1,2,3,0,... one per cycle; responses appear 6 cycles after each grant on consecutive cycles with matching ids.
REQ-034 Fairness skip: ptr=2, req_valid=1001 -> grant 3, then ptr=0; next cycle grant 0.
REQ-035 Halt: four operations in flight, halt=1 -> no further req_ready; all four responses are delivered; busy falls the cycle after the last rsp_valid.
REQ-036 Reset mid-flight: rst pulsed for one cycle 2 cycles after 3 transfers -> zero rsp_valid afterward, ptr=0, busy=0; a new request after reset completes with latency 6.
